ram_arbiter_2p: RTL and testbench

RAM_ARBITER_2P -- requirements
Module: ram_arbiter_2p

---
 rtl/ram_arbiter_2p_if.sv | 60 ++++++
 rtl/ram_arbiter_2p.sv | 154 +++++++++++++++
 tb/tb_ram_arbiter_2p.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_2p_if.sv
// ============================================================================
//  Module      : ram_arbiter_2p_if
//  Description : Bundle of the two requester ports and the single-port RAM
//                command port of the two-requester RAM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_arbiter_2p_if #(
    parameter int N = 4,    // address width in bits
    parameter int W = 8     // data width in bits
);
    // Requester 0
    logic         req0_valid;
    logic         req0_Wr_Rd;
    logic [N-1:0] req0_ADDR;
    logic [W-1:0] req0_WDATA;
    logic         req0_ready;
    logic [W-1:0] req0_RDATA;

    // Requester 1
    logic         req1_valid;
    logic         req1_Wr_Rd;
    logic [N-1:0] req1_ADDR;
    logic [W-1:0] req1_WDATA;
    logic         req1_ready;
    logic [W-1:0] req1_RDATA;

    // RAM command port
    logic         mem_valid;
    logic         mem_Wr_Rd;
    logic [N-1:0] mem_ADDR;
    logic [W-1:0] mem_WDATA;
    logic [W-1:0] mem_RDATA;

    // Status
    logic         busy;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_Wr_Rd, req0_ADDR, req0_WDATA,
        input  req1_valid, req1_Wr_Rd, req1_ADDR, req1_WDATA,
        input  mem_RDATA,
        output req0_ready, req0_RDATA, req1_ready, req1_RDATA,
        output mem_valid, mem_Wr_Rd, mem_ADDR, mem_WDATA,
        output busy
    );

    // Environment side: both requesters plus the RAM
    modport master (
        output req0_valid, req0_Wr_Rd, req0_ADDR, req0_WDATA,
        output req1_valid, req1_Wr_Rd, req1_ADDR, req1_WDATA,
        output mem_RDATA,
        input  req0_ready, req0_RDATA, req1_ready, req1_RDATA,
        input  mem_valid, mem_Wr_Rd, mem_ADDR, mem_WDATA,
        input  busy
    );
endinterface

`default_nettype wire

// File: rtl/ram_arbiter_2p.sv
// ============================================================================
//  Module      : ram_arbiter_2p
//  Description : Arbitrates two requesters onto one single-port RAM. One
//                command is in flight at a time: IDLE -> ISSUE -> (RD_WAIT)
//                -> DONE. Ties are resolved round-robin by default.
//                Build option RAM_ARB_FIXED_PRIO_EN: requester 0 always wins
//                ties and no last-granted pointer exists.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter_2p #(
    parameter int N = 4,    // address width in bits
    parameter int W = 8     // data width in bits
) (
    input  wire logic       clk,
    input  wire logic       rst,    // asynchronous, active low
    ram_arbiter_2p_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RD_WAIT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_next;

    logic         r_win;        // 0 = requester 0 owns the latched command
    logic         r_wr;
    logic [N-1:0] r_addr;
    logic [W-1:0] r_wdata;
    logic [W-1:0] r_rdata0;
    logic [W-1:0] r_rdata1;

    logic         w_any;
    logic         w_grant1;     // requester 1 wins this IDLE cycle
    logic         w_mem_valid;
    logic         w_ready0;
    logic         w_ready1;
    logic         w_busy;

    assign w_any = bus.req0_valid | bus.req1_valid;

`ifdef RAM_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it asks; requester 1 only when alone
    assign w_grant1 = ~bus.req0_valid;
`else
    logic r_last;               // requester served by the previous command

    // A tie goes to whichever requester was not served last
    always_comb begin
        w_grant1 = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant1 = ~r_last;
        end
    end

    // Last-granted pointer, updated when a command retires
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= 1'b1;
        end else if (r_state == S_DONE) begin
            r_last <= r_win;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next      = r_state;
        w_mem_valid = 1'b0;
        w_ready0    = 1'b0;
        w_ready1    = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_any) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_mem_valid = 1'b1;
                w_next      = r_wr ? S_DONE : S_RD_WAIT;
            end
            S_RD_WAIT: begin
                w_mem_valid = 1'b1;
                w_next      = S_DONE;
            end
            S_DONE: begin
                w_ready0 = ~r_win;
                w_ready1 = r_win;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Latch the winner's command; later field changes are ignored until IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win   <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == S_IDLE && w_any) begin
            r_win   <= w_grant1;
            r_wr    <= w_grant1 ? bus.req1_Wr_Rd : bus.req0_Wr_Rd;
            r_addr  <= w_grant1 ? bus.req1_ADDR  : bus.req0_ADDR;
            r_wdata <= w_grant1 ? bus.req1_WDATA : bus.req0_WDATA;
        end
    end

    // Read data is captured only for the requester whose read is finishing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (r_state == S_RD_WAIT) begin
            if (r_win) begin
                r_rdata1 <= bus.mem_RDATA;
            end else begin
                r_rdata0 <= bus.mem_RDATA;
            end
        end
    end

    assign bus.mem_valid  = w_mem_valid;
    assign bus.mem_Wr_Rd  = r_wr;
    assign bus.mem_ADDR   = r_addr;
    assign bus.mem_WDATA  = r_wdata;
    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.req0_RDATA = r_rdata0;
    assign bus.req1_RDATA = r_rdata1;
    assign bus.busy       = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter_2p.sv
// ============================================================================
//  Module      : tb_ram_arbiter_2p
//  Description : Self-checking bench for ram_arbiter_2p: directed scenarios
//                followed by random two-requester traffic, compared every
//                cycle against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter_2p;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 1 << N;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ram_arbiter_2p_if #(.N(N), .W(W)) bus ();

    ram_arbiter_2p #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- RAM behind the arbiter ----------------
    logic [W-1:0] ram [DEPTH];
    logic         ram_clr;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
        end else if (bus.mem_valid && bus.mem_Wr_Rd) begin
            ram[bus.mem_ADDR] <= bus.mem_WDATA;
        end
    end

    assign bus.mem_RDATA = ram[bus.mem_ADDR];

    // ---------------- Bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- Transaction-level reference model ----------------
    // A command accepted at an IDLE edge occupies the RAM for 1 (write) or
    // 2 (read) cycles, then shows ready for one cycle: ready lands at cycle
    // 2 (write) or 3 (read) after acceptance.
    int           m_age;        // cycles since acceptance, 0 = nothing in flight
    bit           m_win;
    bit           m_wr;
    bit           m_last;
    logic [N-1:0] m_addr;
    logic [W-1:0] m_wdata;
    logic [W-1:0] m_rd [2];
    logic [W-1:0] exp_mem [DEPTH];
    bit           m_done [2];
    bit           act [2];

    function automatic int lat();
        return m_wr ? 2 : 3;
    endfunction

    task automatic model_reset();
        m_age   = 0;
        m_win   = 1'b0;
        m_wr    = 1'b0;
        m_last  = 1'b1;
        m_addr  = '0;
        m_wdata = '0;
        m_rd[0] = '0;
        m_rd[1] = '0;
        m_done[0] = 1'b0;
        m_done[1] = 1'b0;
    endtask

    task automatic model_edge();
        bit v0, v1, w;
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        if (m_age == 0) begin
            if (v0 || v1) begin
                if (v0 && v1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                    w = 1'b0;
`else
                    w = ~m_last;
`endif
                end else begin
                    w = v1;
                end
                m_win   = w;
                m_wr    = w ? bus.req1_Wr_Rd : bus.req0_Wr_Rd;
                m_addr  = w ? bus.req1_ADDR  : bus.req0_ADDR;
                m_wdata = w ? bus.req1_WDATA : bus.req0_WDATA;
                m_age   = 1;
            end
        end else if (m_age == lat()) begin
            m_last        = m_win;
            m_done[m_win] = 1'b1;
            m_age         = 0;
        end else begin
            if (m_age == 1 && m_wr)  exp_mem[m_addr] = m_wdata;
            if (m_age == 2 && !m_wr) m_rd[m_win]     = exp_mem[m_addr];
            m_age++;
        end
    endtask

    task automatic check_all();
        chk("busy",       32'(bus.busy),       32'(m_age != 0));
        chk("mem_valid",  32'(bus.mem_valid),  32'((m_age == 1) || (m_age == 2 && !m_wr)));
        chk("mem_Wr_Rd",  32'(bus.mem_Wr_Rd),  32'(m_wr));
        chk("mem_ADDR",   32'(bus.mem_ADDR),   32'(m_addr));
        chk("mem_WDATA",  32'(bus.mem_WDATA),  32'(m_wdata));
        chk("req0_ready", 32'(bus.req0_ready), 32'(m_age != 0 && m_age == lat() && !m_win));
        chk("req1_ready", 32'(bus.req1_ready), 32'(m_age != 0 && m_age == lat() && m_win));
        chk("req0_RDATA", 32'(bus.req0_RDATA), 32'(m_rd[0]));
        chk("req1_RDATA", 32'(bus.req1_RDATA), 32'(m_rd[1]));
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"},   32'(bus.busy),       32'd0);
        chk({tag, "_mvalid"}, 32'(bus.mem_valid),  32'd0);
        chk({tag, "_mwr"},    32'(bus.mem_Wr_Rd),  32'd0);
        chk({tag, "_maddr"},  32'(bus.mem_ADDR),   32'd0);
        chk({tag, "_mwdata"}, 32'(bus.mem_WDATA),  32'd0);
        chk({tag, "_rdy0"},   32'(bus.req0_ready), 32'd0);
        chk({tag, "_rdy1"},   32'(bus.req1_ready), 32'd0);
        chk({tag, "_rdata0"}, 32'(bus.req0_RDATA), 32'd0);
        chk({tag, "_rdata1"}, 32'(bus.req1_RDATA), 32'd0);
    endtask

    // One clock: advance the model on the edge, compare at the falling edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input int i, input bit v, input bit wr,
                         input logic [N-1:0] a, input logic [W-1:0] d);
        if (i == 0) begin
            bus.req0_valid = v; bus.req0_Wr_Rd = wr; bus.req0_ADDR = a; bus.req0_WDATA = d;
        end else begin
            bus.req1_valid = v; bus.req1_Wr_Rd = wr; bus.req1_ADDR = a; bus.req1_WDATA = d;
        end
    endtask

    int exp_tie;

    initial begin
        // ---------- power-on reset ----------
        rst     = 1'b0;
        ram_clr = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_values("por");
        ram_clr = 1'b0;
        rst     = 1'b1;

        // ---------- write: req0 ADDR=3 WDATA=A5 ----------
        drive(0, 1'b1, 1'b1, 4'd3, 8'hA5);
        tick();
        chk("wr_strobe", 32'(bus.mem_valid), 32'd1);
        chk("wr_dir",    32'(bus.mem_Wr_Rd), 32'd1);
        tick();
        chk("wr_ready_at_2", 32'(bus.req0_ready), 32'd1);
        chk("wr_strobe_off", 32'(bus.mem_valid),  32'd0);
        tick();
        drive(0, 1'b0, 1'b0, '0, '0);

        // ---------- readback: req1 ADDR=3 ----------
        drive(1, 1'b1, 1'b0, 4'd3, 8'h00);
        tick();
        chk("rd_strobe_c1", 32'(bus.mem_valid), 32'd1);
        tick();
        chk("rd_strobe_c2", 32'(bus.mem_valid), 32'd1);
        tick();
        chk("rd_ready_at_3", 32'(bus.req1_ready), 32'd1);
        chk("rd_data1",      32'(bus.req1_RDATA), 32'hA5);
        chk("rd_data0_kept", 32'(bus.req0_RDATA), 32'h00);
        tick();
        drive(1, 1'b0, 1'b0, '0, '0);

        // ---------- abort: req0 drops valid and scrambles fields in ISSUE ----------
        drive(0, 1'b1, 1'b1, 4'd5, 8'h3C);
        tick();
        drive(0, 1'b0, 1'b0, 4'd9, 8'hFF);
        tick();
        chk("abort_ready", 32'(bus.req0_ready), 32'd1);
        chk("abort_addr",  32'(bus.mem_ADDR),   32'd5);
        tick();
        chk("abort_single_pulse", 32'(bus.req0_ready), 32'd0);

        // ---------- reset while in RD_WAIT ----------
        drive(1, 1'b1, 1'b0, 4'd5, 8'h00);
        tick();
        tick();
        chk("pre_rst_rdwait", 32'(bus.mem_valid), 32'd1);
        #2 rst = 1'b0;
        #1 chk_reset_values("midrst");
        model_reset();
        drive(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk_reset_values("inrst");
        rst = 1'b1;
        drive(0, 1'b1, 1'b0, 4'd5, 8'h00);
        tick();
        tick();
        tick();
        chk("post_rst_ready", 32'(bus.req0_ready), 32'd1);
        chk("post_rst_data",  32'(bus.req0_RDATA), 32'h3C);
        tick();
        drive(0, 1'b0, 1'b0, '0, '0);

        // ---------- tie: both valid continuously from reset ----------
        rst = 1'b0;
        model_reset();
        drive(0, 1'b1, 1'b1, 4'd1, 8'h11);
        drive(1, 1'b1, 1'b1, 4'd2, 8'h22);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tick();
`ifdef RAM_ARB_FIXED_PRIO_EN
            exp_tie = 1;
`else
            exp_tie = (k % 2 == 0) ? 1 : 2;
`endif
            chk($sformatf("tie_grant_%0d", k),
                32'({bus.req1_ready, bus.req0_ready}), 32'(exp_tie));
            tick();
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);

        // ---------- random two-requester traffic ----------
        act[0] = 1'b0; act[1] = 1'b0;
        m_done[0] = 1'b0; m_done[1] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (m_done[i]) begin
                    act[i]    = 1'b0;
                    m_done[i] = 1'b0;
                end
                if (!act[i]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        act[i] = 1'b1;
                        drive(i, 1'b1, 1'($urandom_range(0, 1)),
                              N'($urandom_range(0, DEPTH - 1)), W'($urandom));
                    end else begin
                        drive(i, 1'b0, 1'b0, '0, '0);
                    end
                end else if (m_age != 0 && m_win == 1'(i) && $urandom_range(0, 7) == 0) begin
                    // Owner of the latched command misbehaves; must not matter
                    drive(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          N'($urandom_range(0, DEPTH - 1)), W'($urandom));
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
